dpram_tdp_ctl: RTL

Parametrised single-clock true dual-port RAM. It generalises the team's two-write-port BRAM wrapper with byte-lane write enables, selectable read latency and per-port write mode, and deterministic same-address collision resolution. It also has a built-in clear engine that fills the array with a constant after reset or on request. Used as tile/sprite/work RAM shared between a CPU port and a video/DMA port.

---
 rtl/dpram_tdp_ctl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/dpram_tdp_ctl.sv
// Single-clock true dual-port RAM: byte lanes, 1/2-cycle read latency, per-port write mode, clear engine.
// Latency: read_latency_g cycles from accepted access to q/valid; collision flag follows the same pipe.
// Backpressure: none; accesses are dropped (no write, no valid) while the clear engine is busy.
module dpram_tdp_ctl #(
    parameter int addr_width_g     = 8,
    parameter int data_width_g     = 8,
    parameter int byte_width_g     = 8,
    parameter int read_latency_g   = 1,
    parameter int write_mode_g     = 0,
    parameter int clear_on_reset_g = 1,
    parameter logic [data_width_g-1:0] clear_value_g = '0,
    localparam int lanes_c         = data_width_g / byte_width_g
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    clear,
    output logic                    busy,
    input  logic                    en_a,
    input  logic                    wren_a,
    input  logic [lanes_c-1:0]      be_a,
    input  logic [addr_width_g-1:0] address_a,
    input  logic [data_width_g-1:0] data_a,
    output logic [data_width_g-1:0] q_a,
    output logic                    valid_a,
    input  logic                    en_b,
    input  logic                    wren_b,
    input  logic [lanes_c-1:0]      be_b,
    input  logic [addr_width_g-1:0] address_b,
    input  logic [data_width_g-1:0] data_b,
    output logic [data_width_g-1:0] q_b,
    output logic                    valid_b,
    output logic                    collision
);

    localparam int depth_c = 1 << addr_width_g;

    typedef enum logic {
        st_idle,
        st_clear
    } state_t;

    state_t                  state;
    logic [addr_width_g-1:0] counter;
    logic [data_width_g-1:0] mem [depth_c];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= (clear_on_reset_g != 0) ? st_clear : st_idle;
            busy    <= (clear_on_reset_g != 0);
            counter <= '0;
        end else begin
            case (state)
                st_idle: begin
                    if (clear) begin
                        state   <= st_clear;
                        busy    <= 1'b1;
                        counter <= '0;
                    end
                end
                st_clear: begin
                    counter <= counter + 1'b1;
                    if (&counter) begin
                        state <= st_idle;
                        busy  <= 1'b0;
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

    function automatic logic [data_width_g-1:0] merge(input logic [data_width_g-1:0] base,
                                                      input logic [data_width_g-1:0] dat,
                                                      input logic [lanes_c-1:0]      be);
        logic [data_width_g-1:0] r;
        r = base;
        for (int i = 0; i < lanes_c; i++) begin
            if (be[i]) r[i*byte_width_g +: byte_width_g] = dat[i*byte_width_g +: byte_width_g];
        end
        return r;
    endfunction

    logic                    acc_a, acc_b, wr_a, wr_b, same_row, collide;
    logic                    fire_a, fire_b;
    logic [lanes_c-1:0]      lanes_a, lanes_b;
    logic [data_width_g-1:0] old_a, old_b, new_a, new_b, rd_a, rd_b;

    // On a same-row double write, A lanes are overlaid last so A wins, and both
    // ports compute the identical final word; write order into mem is then irrelevant.
    always_comb begin
        acc_a    = en_a & ~busy;
        acc_b    = en_b & ~busy;
        wr_a     = acc_a & wren_a;
        wr_b     = acc_b & wren_b;
        lanes_a  = wr_a ? be_a : '0;
        lanes_b  = wr_b ? be_b : '0;
        same_row = acc_a & acc_b & (address_a == address_b);
        collide  = same_row & (wren_a | wren_b);
        old_a    = mem[address_a];
        old_b    = mem[address_b];
        new_a    = merge(merge(old_a, data_b, same_row ? lanes_b : '0), data_a, lanes_a);
        new_b    = merge(merge(old_b, data_b, lanes_b), data_a, same_row ? lanes_a : '0);
        rd_a     = (wren_a && write_mode_g == 0) ? new_a : old_a;
        rd_b     = (wren_b && write_mode_g == 0) ? new_b : old_b;
        fire_a   = acc_a & ~(wren_a & (write_mode_g == 2));
        fire_b   = acc_b & ~(wren_b & (write_mode_g == 2));
    end

    always_ff @(posedge clock) begin
        if (busy) begin
            mem[counter] <= clear_value_g;
        end else begin
            if (wr_b) mem[address_b] <= new_b;
            if (wr_a) mem[address_a] <= new_a;
        end
    end

    logic                    p1_vld_a, p1_vld_b, p1_col;
    logic [data_width_g-1:0] p1_dat_a, p1_dat_b;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p1_vld_a <= 1'b0;
            p1_vld_b <= 1'b0;
            p1_col   <= 1'b0;
            p1_dat_a <= '0;
            p1_dat_b <= '0;
        end else begin
            p1_vld_a <= fire_a;
            p1_vld_b <= fire_b;
            p1_col   <= collide;
            if (fire_a) p1_dat_a <= rd_a;
            if (fire_b) p1_dat_b <= rd_b;
        end
    end

    generate
        if (read_latency_g == 2) begin : g_lat2
            logic                    p2_vld_a, p2_vld_b, p2_col;
            logic [data_width_g-1:0] p2_dat_a, p2_dat_b;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    p2_vld_a <= 1'b0;
                    p2_vld_b <= 1'b0;
                    p2_col   <= 1'b0;
                    p2_dat_a <= '0;
                    p2_dat_b <= '0;
                end else begin
                    p2_vld_a <= p1_vld_a;
                    p2_vld_b <= p1_vld_b;
                    p2_col   <= p1_col;
                    if (p1_vld_a) p2_dat_a <= p1_dat_a;
                    if (p1_vld_b) p2_dat_b <= p1_dat_b;
                end
            end

            assign q_a       = p2_dat_a;
            assign q_b       = p2_dat_b;
            assign valid_a   = p2_vld_a;
            assign valid_b   = p2_vld_b;
            assign collision = p2_col;
        end else begin : g_lat1
            assign q_a       = p1_dat_a;
            assign q_b       = p1_dat_b;
            assign valid_a   = p1_vld_a;
            assign valid_b   = p1_vld_b;
            assign collision = p1_col;
        end
    endgenerate

endmodule
